// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
// Execute stage of the five-stage ARM pipeline. It builds the second ALU
// operand (val2) from the shifter operand field and runs the ALU. It also
// updates the NZCV status register, computes the branch target, and
// registers the results into the EXE/MEM pipeline register.
//
// Ports
//   clk, rst             rising-edge clock; asynchronous active-low reset
//   freeze               stall: holds the EXE/MEM register and status
//   pc_in                PC+4 of the instruction in EXE
//   exe_cmd              ALU command
//   wb_en, mem_r_en,
//   mem_w_en             control bits forwarded to MEM
//   s_en                 update status flags
//   b                    branch (condition already resolved upstream)
//   imm                  immediate operand form
//   val_rn, val_rm       register operands
//   shift_operand        ARM shifter operand field
//   signed_imm24         branch word offset
//   dest                 destination register
//   branch_taken         combinational copy of b
//   branch_address       combinational branch target
//   status               registered {N,Z,C,V}
//   *_out                EXE/MEM register contents
// ---------------------------------------------------------------------------
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [31:0] pc_in,
    input  logic [3:0]  exe_cmd,
    input  logic        wb_en,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        s_en,
    input  logic        b,
    input  logic        imm,
    input  logic [31:0] val_rn,
    input  logic [31:0] val_rm,
    input  logic [11:0] shift_operand,
    input  logic [23:0] signed_imm24,
    input  logic [3:0]  dest,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [3:0]  status,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] val_rm_out,
    output logic [3:0]  dest_out
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Rotate right; the doubled word makes a zero amount fall out naturally.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] dbl;
        dbl    = {x, x} >> n;
        ror32  = dbl[31:0];
    endfunction

    function automatic logic [31:0] gen_val2(
        input logic        mem_en,
        input logic        imm_f,
        input logic [11:0] so,
        input logic [31:0] rm
    );
        logic signed [31:0] rm_s;
        logic [4:0]         sh;
        rm_s = $signed(rm);
        sh   = so[11:7];
        if (mem_en) begin
            // Load/store offsets are plain 12-bit unsigned immediates.
            gen_val2 = {20'd0, so};
        end else if (imm_f) begin
            gen_val2 = ror32({24'd0, so[7:0]}, {so[11:8], 1'b0});
        end else begin
            case (so[6:5])
                2'b00:   gen_val2 = rm << sh;
                2'b01:   gen_val2 = rm >> sh;
                2'b10:   gen_val2 = $unsigned(rm_s >>> sh);
                default: gen_val2 = ror32(rm, sh);
            endcase
        end
    endfunction

    // ---- EXE stage (combinational, _p0) ----
    logic [31:0]        val2_p0;
    logic signed [31:0] op_a_p0;
    logic signed [31:0] op_b_p0;
    logic [31:0]        alu_res_p0;
    logic               c_p0;
    logic               v_p0;
    logic [3:0]         nzcv_p0;
    logic signed [31:0] br_off_p0;

    assign val2_p0 = gen_val2(mem_r_en | mem_w_en, imm, shift_operand, val_rm);
    assign op_a_p0 = $signed(val_rn);
    assign op_b_p0 = $signed(val2_p0);

    always_comb begin
        alu_res_p0 = '0;
        c_p0       = status[1];
        v_p0       = status[0];
        case (exe_cmd)
            CMD_MOV: alu_res_p0 = op_b_p0;
            CMD_MVN: alu_res_p0 = ~op_b_p0;
            CMD_ADD, CMD_ADC: begin
                {c_p0, alu_res_p0} = {1'b0, op_a_p0} + {1'b0, op_b_p0}
                                   + {32'd0, (exe_cmd == CMD_ADC) & status[1]};
                v_p0 = (op_a_p0[31] == op_b_p0[31]) && (alu_res_p0[31] != op_a_p0[31]);
            end
            CMD_SUB, CMD_SBC: begin
                // A + ~B + carry-in; carry out is the ARM NOT-borrow flag.
                {c_p0, alu_res_p0} = {1'b0, op_a_p0} + {1'b0, ~op_b_p0}
                                   + {32'd0, (exe_cmd == CMD_SUB) | status[1]};
                v_p0 = (op_a_p0[31] != op_b_p0[31]) && (alu_res_p0[31] != op_a_p0[31]);
            end
            CMD_AND: alu_res_p0 = op_a_p0 & op_b_p0;
            CMD_ORR: alu_res_p0 = op_a_p0 | op_b_p0;
            CMD_EOR: alu_res_p0 = op_a_p0 ^ op_b_p0;
            default: alu_res_p0 = '0;
        endcase
    end

    assign nzcv_p0 = {alu_res_p0[31], (alu_res_p0 == 32'd0), c_p0, v_p0};

    assign br_off_p0      = {{6{signed_imm24[23]}}, signed_imm24, 2'b00};
    assign branch_address = pc_in + $unsigned(br_off_p0);
    assign branch_taken   = b;

    // ---- EXE/MEM register and status (_p1 boundary) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status         <= '0;
            wb_en_out      <= 1'b0;
            mem_r_en_out   <= 1'b0;
            mem_w_en_out   <= 1'b0;
            alu_result_out <= '0;
            val_rm_out     <= '0;
            dest_out       <= '0;
        end else if (!freeze) begin
            if (s_en) status <= nzcv_p0;
            wb_en_out      <= wb_en;
            mem_r_en_out   <= mem_r_en;
            mem_w_en_out   <= mem_w_en;
            alu_result_out <= alu_res_p0;
            val_rm_out     <= val_rm;
            dest_out       <= dest;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic [31:0] pc_in;
    logic [3:0]  exe_cmd;
    logic        wb_en, mem_r_en, mem_w_en, s_en, b, imm;
    logic [31:0] val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic [3:0]  dest;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [3:0]  status;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] alu_result_out, val_rm_out;
    logic [3:0]  dest_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in), .exe_cmd(exe_cmd),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .s_en(s_en),
        .b(b), .imm(imm), .val_rn(val_rn), .val_rm(val_rm),
        .shift_operand(shift_operand), .signed_imm24(signed_imm24), .dest(dest),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .status(status), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .alu_result_out(alu_result_out),
        .val_rm_out(val_rm_out), .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_val2(input logic mr, input logic mw, input logic im,
                                           input logic [11:0] so, input logic [31:0] rm);
        logic [31:0] x;
        int n;
        if (mr || mw) return 32'(so);
        if (im) begin
            x = {24'd0, so[7:0]};
            n = 2 * int'(so[11:8]);
            for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
            return x;
        end
        x = rm;
        n = int'(so[11:7]);
        case (so[6:5])
            2'd0: return x << n;
            2'd1: return x >> n;
            2'd2: begin
                for (int i = 0; i < n; i++) x = {x[31], x[31:1]};
                return x;
            end
            default: begin
                for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
                return x;
            end
        endcase
    endfunction

    // Returns {N,Z,C,V, result}.
    function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] bv, input logic [3:0] st);
        longint ua, ub, sa, sb, u, s, bor;
        logic [31:0] r;
        logic c, v, arith;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, bv});
        sa = $signed(a);
        sb = $signed(bv);
        c = st[1];
        v = st[0];
        arith = 1'b1;
        u = 0;
        s = 0;
        bor = st[1] ? 0 : 1;
        r = 32'd0;
        case (cmd)
            4'b0010: begin u = ua + ub; s = sa + sb; c = (u >= 64'sd4294967296); end
            4'b0011: begin
                u = ua + ub + (1 - bor); s = sa + sb + (1 - bor); c = (u >= 64'sd4294967296);
            end
            4'b0100: begin u = ua - ub; s = sa - sb; c = (ua >= ub); end
            4'b0101: begin u = ua - ub - bor; s = sa - sb - bor; c = (ua >= ub + bor); end
            4'b0001: begin arith = 1'b0; r = bv; end
            4'b1001: begin arith = 1'b0; r = ~bv; end
            4'b0110: begin arith = 1'b0; r = a & bv; end
            4'b0111: begin arith = 1'b0; r = a | bv; end
            4'b1000: begin arith = 1'b0; r = a ^ bv; end
            default: begin arith = 1'b0; r = 32'd0; end
        endcase
        if (arith) begin
            r = u[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic logic [31:0] m_br(input logic [31:0] pc, input logic [23:0] off24);
        int off;
        off = $signed(off24);
        return pc + 32'(off * 4);
    endfunction

    logic [31:0] m_res = '0, m_rm = '0;
    logic [3:0]  m_dest = '0, m_status = '0;
    logic        m_wb = 1'b0, m_mr = 1'b0, m_mw = 1'b0;
    logic [35:0] m_o;

    always_comb m_o = m_alu(exe_cmd, val_rn,
                            m_val2(mem_r_en, mem_w_en, imm, shift_operand, val_rm), m_status);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_res <= '0; m_rm <= '0; m_dest <= '0; m_status <= '0;
            m_wb <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
        end else if (!freeze) begin
            m_res  <= m_o[31:0];
            m_rm   <= val_rm;
            m_dest <= dest;
            m_wb   <= wb_en;
            m_mr   <= mem_r_en;
            m_mw   <= mem_w_en;
            if (s_en) m_status <= m_o[35:32];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model comparison on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("res",      alu_result_out, m_res);
            check("status",   {28'd0, status}, {28'd0, m_status});
            check("val_rm",   val_rm_out, m_rm);
            check("dest",     {28'd0, dest_out}, {28'd0, m_dest});
            check("ctrl",     {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out},
                              {29'd0, m_wb, m_mr, m_mw});
            check("br_taken", {31'd0, branch_taken}, {31'd0, b});
            check("br_addr",  branch_address, m_br(pc_in, signed_imm24));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic setop(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] so, input logic im, input logic s, input logic [3:0] d);
        exe_cmd = cmd; val_rn = rn; val_rm = rm; shift_operand = so;
        imm = im; s_en = s; dest = d;
        wb_en = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; b = 1'b0;
    endtask

    task automatic lit(input logic [31:0] res, input logic [3:0] st);
        check("lit_res", alu_result_out, res);
        check("lit_status", {28'd0, status}, {28'd0, st});
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, alu_result_out | val_rm_out, 32'd0);
        check(nm, {21'd0, status, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; pc_in = 32'h0; signed_imm24 = 24'h0;
        setop(4'b0010, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0, 4'h0);
        chk_en = 1'b1;
        // Reset held with arbitrary inputs toggling.
        for (int i = 0; i < 3; i++) begin
            setop(4'($urandom_range(0, 15)), $urandom, $urandom, 12'($urandom),
                  1'($urandom), 1'b1, 4'($urandom));
            mem_w_en = 1'b1;
            tick;
            check_all_zero("reset_hold");
        end
        rst = 1'b1;

        setop(4'b0010, 32'h7FFFFFFF, 32'h0, 12'h001, 1'b1, 1'b1, 4'd1); tick;
        lit(32'h80000000, 4'b1001);
        setop(4'b0100, 32'd5, 32'h0, 12'h005, 1'b1, 1'b1, 4'd2); tick;
        lit(32'h0, 4'b0110);
        setop(4'b0101, 32'd3, 32'h0, 12'h001, 1'b1, 1'b1, 4'd3); tick;
        lit(32'd2, 4'b0010);
        setop(4'b0001, 32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 4'd4); tick;
        lit(32'hFF000000, 4'b0010);
        setop(4'b0001, 32'h0, 32'h80000000, 12'h240, 1'b0, 1'b1, 4'd5); tick;
        lit(32'hF8000000, 4'b1010);

        // Branch: target is combinational, instruction still flows with wb_en=0.
        setop(4'b0000, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0, 4'd6);
        wb_en = 1'b0; b = 1'b1; pc_in = 32'h100; signed_imm24 = 24'hFFFFFE;
        #1;
        check("lit_br_addr", branch_address, 32'hF8);
        check("lit_br_taken", {31'd0, branch_taken}, 32'd1);
        tick;
        check("lit_br_ctrl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd0);

        setop(4'b0010, 32'h400, 32'h0, 12'h804, 1'b0, 1'b0, 4'd7); mem_r_en = 1'b1; tick;
        lit(32'hC04, 4'b1010);
        check("lit_ldr_ctrl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd6);
        setop(4'b0010, 32'h1000, 32'hDEADBEEF, 12'h010, 1'b0, 1'b0, 4'd8);
        wb_en = 1'b0; mem_w_en = 1'b1; tick;
        check("lit_str_res", alu_result_out, 32'h1010);
        check("lit_str_data", val_rm_out, 32'hDEADBEEF);

        setop(4'b0011, 32'hFFFFFFFF, 32'h0, 12'h001, 1'b1, 1'b1, 4'd9); tick;
        lit(32'd1, 4'b0010);
        setop(4'b0001, 32'h0, 32'h3, 12'h200, 1'b0, 1'b0, 4'd1); tick;
        lit(32'h30, 4'b0010);
        setop(4'b0001, 32'h0, 32'hF0000000, 12'h420, 1'b0, 1'b0, 4'd2); tick;
        lit(32'h00F00000, 4'b0010);
        setop(4'b0001, 32'h0, 32'h0000000F, 12'h260, 1'b0, 1'b0, 4'd3); tick;
        lit(32'hF0000000, 4'b0010);
        setop(4'b0001, 32'h0, 32'h12345678, 12'h060, 1'b0, 1'b0, 4'd4); tick;
        lit(32'h12345678, 4'b0010);
        setop(4'b1001, 32'h0, 32'h0, 12'h000, 1'b1, 1'b0, 4'd5); tick;
        lit(32'hFFFFFFFF, 4'b0010);
        setop(4'b0110, 32'h0F0F0F0F, 32'h0, 12'h0FF, 1'b1, 1'b0, 4'd6); tick;
        lit(32'h0F, 4'b0010);
        setop(4'b1000, 32'hFF, 32'h0, 12'h00F, 1'b1, 1'b0, 4'd7); tick;
        lit(32'hF0, 4'b0010);
        setop(4'b0100, 32'd1, 32'h0, 12'h002, 1'b1, 1'b1, 4'd8); tick;
        lit(32'hFFFFFFFF, 4'b1000);
        setop(4'b0101, 32'd5, 32'h0, 12'h002, 1'b1, 1'b1, 4'd9); tick;
        lit(32'd2, 4'b0010);
        setop(4'b0100, 32'h80000000, 32'h0, 12'h001, 1'b1, 1'b1, 4'd10); tick;
        lit(32'h7FFFFFFF, 4'b0011);
        setop(4'b1111, 32'hAAAA, 32'h0, 12'h0FF, 1'b1, 1'b1, 4'd11); tick;
        lit(32'h0, 4'b0111);
        setop(4'b0111, 32'hF0, 32'h0, 12'h00F, 1'b1, 1'b1, 4'd7); tick;
        lit(32'hFF, 4'b0011);

        // Freeze with s_en held high and changing inputs.
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setop(4'b0100, 32'(5 + i), 32'(i), 12'h005, 1'b1, 1'b1, 4'(i));
            tick;
            lit(32'hFF, 4'b0011);
            check("lit_frz_dest", {28'd0, dest_out}, 32'd7);
        end
        freeze = 1'b0;
        setop(4'b0100, 32'd5, 32'h0, 12'h005, 1'b1, 1'b1, 4'd9); tick;
        lit(32'h0, 4'b0110);
        check("lit_rel_dest", {28'd0, dest_out}, 32'd9);

        // Reset asserted between clock edges.
        rst = 1'b0;
        #1;
        check_all_zero("reset_async");
        tick;
        rst = 1'b1;
        tick;
        tick;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage ARM pipeline, together with its EXE/MEM pipeline register and the NZCV status register. It consumes the decoded fields held in the ID/EXE register and does the following:
- forms the second operand (val2);
- runs the ALU;
- updates the status flags;
- computes the branch target fed back to instruction fetch;
- registers the results for the memory stage.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall; holds the EXE/MEM register and the status register.
- pc_in  in  32  PC+4 of the instruction in EXE.
- exe_cmd  in  4  ALU command.
- wb_en, mem_r_en, mem_w_en  in  1 each  control bits passed through to MEM.
- s_en  in  1  update flags.
- b  in  1  branch (condition already resolved in ID).
- imm  in  1  immediate operand form.
- val_rn, val_rm  in  32 each  register operands.
- shift_operand  in  12  ARM shifter operand field.
- signed_imm24  in  24  branch offset.
- dest  in  4  destination register.
- branch_taken  out  1  combinational; equals b.
- branch_address  out  32  combinational branch target.
- status  out  4  registered {N,Z,C,V}.
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered.
- alu_result_out  out  32  registered.
- val_rm_out  out  32  registered store data.
- dest_out  out  4  registered.

## Operation
- val2 generation:
  - mem_r_en|mem_w_en: val2 = zero-extended shift_operand[11:0].
  - else imm=1: val2 = {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - else register form: shift_operand[6:5] selects 00 LSL, 01 LSR, 10 ASR, 11 ROR applied to val_rm, by shift_operand[11:7].
  - Register-form shift amount 0 passes val_rm unchanged for all four types; no RRX.
- ALU, with A=val_rn, B=val2, Cin=status C:
  - 0001 MOV: B.
  - 1001 MVN: ~B.
  - 0010 ADD: A+B.
  - 0011 ADC: A+B+Cin.
  - 0100 SUB: A−B.
  - 0101 SBC: A−B−!Cin.
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - Other codes: result 0, flags as for a logic op.
- Flag generation:
  - N = result[31]; Z = (result==0).
  - Add forms: C = carry out of bit 31.
  - Subtract forms: C = NOT borrow (A≥B unsigned for SUB).
  - V = signed overflow for add/sub.
  - Logic and move ops: C and V keep their current value.
- Status register: loads the new NZCV on the rising edge when s_en=1 and freeze=0; otherwise it holds.
- branch_address = pc_in + (sign-extend(signed_imm24) << 2), modulo 2^32.
- EXE/MEM register, on each rising edge with freeze=0, loads:
  - the three control bits,
  - the ALU result,
  - val_rm,
  - dest.
- With freeze=1, every registered output holds its value.

## Timing
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk): every registered output, including status, goes to 0. It stays 0 until the first rising edge after rst returns to 1.
- Latency:
  - One cycle from the inputs to the registered outputs and to status.
  - branch_taken and branch_address are combinational in the same cycle.
- status seen by ADC/SBC is the value registered before the current edge. Back-to-back flag-setting instructions therefore chain correctly.
- freeze and s_en asserted together: flags are not updated.
- A branch instruction still enters EXE/MEM. ID supplies wb_en=0 for it. This stage performs no flush.
- Arithmetic wraps modulo 2^32; no exceptions.

## Test plan
- Reset: hold rst=0 with arbitrary inputs and toggle clk. Required: all registered outputs and status stay 0; asserting rst mid-cycle clears them without a clock edge.
- ADD with flags: val_rn=32'h7FFFFFFF, imm=1, shift_operand=12'h001, exe_cmd=0010, s_en=1. Required next cycle: alu_result_out=32'h80000000, status=1001 (N=1, Z=0, C=0, V=1).
- SUB then SBC:
  - SUB 5−5, s_en=1. Required: result 0, status=0110 (Z=1, C=1).
  - Next, SBC 3−1. Required: result 2.
- Rotated immediate and register shift:
  - imm=1, shift_operand=12'h4FF, MOV. Required: 32'hFF000000.
  - Register form, val_rm=32'h80000000, ASR by 4. Required: 32'hF8000000.
- Branch and load offset:
  - pc_in=32'h100, signed_imm24=24'hFFFFFE, b=1. Required: branch_taken=1, branch_address=32'hF8.
  - LDR with val_rn=32'h400, shift_operand=12'h804. Required: alu_result_out=32'hC04.
- Freeze: assert freeze=1 for 3 cycles with changing inputs and s_en=1. Required: all registered outputs and status hold. On release, the current inputs load on the next edge.
